// File: rtl/fsm_code_logger.sv
// Run-length logger for the 4-bit sequencer code stream, buffered in a small FWFT FIFO.
// Optional statistics counters are enabled with `define FSM_CODE_LOGGER_STATS_EN.
module fsm_code_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned RUN_W = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [3:0]               code_in,
    input  logic                     code_vld,
    input  logic                     flush,
    output logic [RUN_W+3:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef FSM_CODE_LOGGER_STATS_EN
    ,
    output logic [15:0]              rec_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned REC_W = RUN_W + 4;

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    typedef enum logic {StIdle, StRun} state_t;

    // ------------------------------------------------------------------
    // Run tracker
    // ------------------------------------------------------------------
    state_t             state, state_nxt;
    logic [3:0]         cur_code, cur_code_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic               push;
    logic [REC_W-1:0]   push_rec;

    always_comb begin
        state_nxt    = state;
        cur_code_nxt = cur_code;
        run_nxt      = run;
        push         = 1'b0;
        push_rec     = '0;
        unique case (state)
            StIdle: begin
                if (code_vld) begin
                    state_nxt    = StRun;
                    cur_code_nxt = code_in;
                    run_nxt      = RUN_ONE;
                end
            end
            StRun: begin
                if (flush) begin
                    push     = 1'b1;
                    push_rec = {cur_code, run};
                    if (code_vld) begin
                        cur_code_nxt = code_in;
                        run_nxt      = RUN_ONE;
                    end else begin
                        state_nxt    = StIdle;
                        cur_code_nxt = 4'h0;
                        run_nxt      = '0;
                    end
                end else if (code_vld) begin
                    if (code_in == cur_code) begin
                        if (run == RUN_MAX) begin
                            // Saturated run is emitted and continues as a fresh record.
                            push     = 1'b1;
                            push_rec = {cur_code, RUN_MAX};
                            run_nxt  = RUN_ONE;
                        end else begin
                            run_nxt = run + RUN_ONE;
                        end
                    end else begin
                        push         = 1'b1;
                        push_rec     = {cur_code, run};
                        cur_code_nxt = code_in;
                        run_nxt      = RUN_ONE;
                    end
                end
            end
            default: begin
                state_nxt    = StIdle;
                cur_code_nxt = 4'h0;
                run_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= StIdle;
            cur_code <= 4'h0;
            run      <= '0;
        end else begin
            state    <= state_nxt;
            cur_code <= cur_code_nxt;
            run      <= run_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [LW-1:0]      level_q, level_nxt;
    logic               valid_q;
    logic               overflow_q;
    logic               full, pop, accept, drop;

    assign full   = (level_q == LVL_FULL);
    assign pop    = valid_q && out_ready;
    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        level_nxt = level_q;
        unique case ({accept, pop})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            level_q <= level_nxt;
            valid_q <= (level_nxt != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_valid = valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign out_data  = valid_q ? mem[rptr] : '0;

`ifdef FSM_CODE_LOGGER_STATS_EN
    logic [15:0] rec_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept && (rec_cnt_q != 16'hFFFF)) begin
                rec_cnt_q <= rec_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign rec_cnt  = rec_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fsm_code_logger.sv
// Directed self-checking bench for fsm_code_logger (default and RUN_W=4 instances).
// Checks the statistics ports as well when FSM_CODE_LOGGER_STATS_EN is defined.
module tb_fsm_code_logger;

    logic        clk;
    logic        rstb;
    logic [3:0]  code_in;
    logic        code_vld;
    logic        flush;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        overflow;

    logic [3:0]  s_code_in;
    logic        s_code_vld;
    logic        s_flush;
    logic [7:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_level;
    logic        s_overflow;

`ifdef FSM_CODE_LOGGER_STATS_EN
    logic [15:0] rec_cnt, drop_cnt, s_rec_cnt, s_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fsm_code_logger #(.DEPTH(8), .RUN_W(8)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .code_in   (code_in),
        .code_vld  (code_vld),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef FSM_CODE_LOGGER_STATS_EN
        ,
        .rec_cnt   (rec_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    fsm_code_logger #(.DEPTH(8), .RUN_W(4)) dut4 (
        .clk       (clk),
        .rstb      (rstb),
        .code_in   (s_code_in),
        .code_vld  (s_code_vld),
        .flush     (s_flush),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .level     (s_level),
        .overflow  (s_overflow)
`ifdef FSM_CODE_LOGGER_STATS_EN
        ,
        .rec_cnt   (s_rec_cnt),
        .drop_cnt  (s_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb      = 1'b0;
        code_in   = 4'h0;
        code_vld  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    initial begin
        rstb        = 1'b0;
        code_in     = 4'h0;
        code_vld    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        s_code_in   = 4'h0;
        s_code_vld  = 1'b0;
        s_flush     = 1'b0;
        s_out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_level",     32'(level),     32'h0);
        chk("rst_overflow",  32'(overflow),  32'h0);
        chk("rst_s_valid",   32'(s_out_valid), 32'h0);
        tick();
        rstb = 1'b1;

        // Basic run: 5 x4, 10 x2, flush while reading
        code_vld = 1'b1;
        code_in  = 4'd5;
        repeat (4) tick();
        code_in = 4'd10;
        tick();
        chk("basic_head1",  32'(out_data),  32'h504);
        chk("basic_valid1", 32'(out_valid), 32'h1);
        chk("basic_level1", 32'(level),     32'h1);
        tick();
        code_vld  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("basic_head2",  32'(out_data), 32'hA02);
        chk("basic_level2", 32'(level),    32'h1);
        tick();
        chk("basic_level0", 32'(level),     32'h0);
        chk("basic_valid0", 32'(out_valid), 32'h0);
        chk("basic_data0",  32'(out_data),  32'h0);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_idle_level", 32'(level), 32'h0);
`ifdef FSM_CODE_LOGGER_STATS_EN
        chk("basic_rec_cnt",  32'(rec_cnt),  32'd2);
        chk("basic_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Flush together with a new code
        code_vld = 1'b1;
        code_in  = 4'd10;
        repeat (3) tick();
        flush   = 1'b1;
        code_in = 4'd5;
        tick();
        flush    = 1'b0;
        code_vld = 1'b0;
        chk("fnew_level1", 32'(level),    32'h1);
        chk("fnew_head1",  32'(out_data), 32'hA03);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fnew_level2", 32'(level), 32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fnew_head2",  32'(out_data), 32'h501);
        chk("fnew_level3", 32'(level),    32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fnew_level0", 32'(level), 32'h0);

        // Full FIFO: 11 pushes into 8 entries
        do_reset();
        code_vld = 1'b1;
        for (int i = 0; i < 12; i++) begin
            code_in = (i % 2 == 1) ? 4'd10 : 4'd5;
            tick();
        end
        code_vld = 1'b0;
        chk("full_level",    32'(level),     32'h8);
        chk("full_overflow", 32'(overflow),  32'h1);
        chk("full_valid",    32'(out_valid), 32'h1);
`ifdef FSM_CODE_LOGGER_STATS_EN
        chk("full_rec_cnt",  32'(rec_cnt),  32'd8);
        chk("full_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_drain%0d", i), 32'(out_data),
                (i % 2 == 0) ? 32'h501 : 32'hA01);
            tick();
        end
        out_ready = 1'b0;
        chk("full_drained",   32'(level),    32'h0);
        chk("full_ovf_stick", 32'(overflow), 32'h1);

        // Reset mid-operation with 3 records held
        code_vld = 1'b1;
        code_in  = 4'd5;
        tick();
        code_in = 4'd10;
        tick();
        code_in = 4'd5;
        tick();
        code_vld = 1'b0;
        chk("mid_level3", 32'(level), 32'h3);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_valid",    32'(out_valid), 32'h0);
        chk("mid_level",    32'(level),     32'h0);
        chk("mid_data",     32'(out_data),  32'h0);
        chk("mid_overflow", 32'(overflow),  32'h0);
        tick();
        rstb     = 1'b1;
        code_vld = 1'b1;
        code_in  = 4'd5;
        tick();
        code_in = 4'd10;
        tick();
        code_vld = 1'b0;
        chk("mid_fresh_run", 32'(out_data), 32'h501);

        // Full with simultaneous pop
        do_reset();
        code_vld = 1'b1;
        for (int i = 0; i < 9; i++) begin
            code_in = (i % 2 == 1) ? 4'd10 : 4'd5;
            tick();
        end
        chk("fpop_level_pre", 32'(level), 32'h8);
        code_in   = 4'd10;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        code_vld  = 1'b0;
        chk("fpop_level",    32'(level),    32'h8);
        chk("fpop_overflow", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fpop_drain%0d", i), 32'(out_data),
                (i % 2 == 0) ? 32'hA01 : 32'h501);
            tick();
        end
        out_ready = 1'b0;
        chk("fpop_drained", 32'(level), 32'h0);

        // Saturation on the RUN_W=4 instance
        s_code_vld = 1'b1;
        s_code_in  = 4'd10;
        repeat (20) tick();
        s_code_vld = 1'b0;
        s_flush    = 1'b1;
        tick();
        s_flush = 1'b0;
        chk("sat_level", 32'(s_level),    32'h2);
        chk("sat_head1", 32'(s_out_data), 32'hAF);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("sat_head2",  32'(s_out_data), 32'hA5);
        chk("sat_level1", 32'(s_level),    32'h1);
        chk("sat_ovf",    32'(s_overflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_code_logger.md
# fsm_code_logger

Downstream consumer of the 4-bit sequencer output code. Compresses the per-cycle code stream into run-length records `{code, run}` and buffers them in a small first-word-fall-through FIFO. A valid/ready interface lets a slower reader drain the trace. It sits between the sequencer's `out` bus and the debug/trace readout.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `RUN_W`, 8: run-length counter width; record width is `RUN_W+4`.

- `clk`  in  1  clock.
- `rstb`  in  1  reset; asynchronous assert, active-low.
- `code_in`  in  4  code from the sequencer, sampled when `code_vld`=1.
- `code_vld`  in  1  `code_in` is valid this cycle.
- `flush`  in  1  close the current run and push it now.
- `out_data`  out  RUN_W+4  head record: `[RUN_W+3:RUN_W]`=code, `[RUN_W-1:0]`=run.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  reader accepts the head record.
- `level`  out  $clog2(DEPTH)+1  number of records held.
- `overflow`  out  1  sticky: a record was dropped because the FIFO was full.

## Operation
- Run tracker states: IDLE (no open run) and RUN (holds `cur_code` and `run`).
- **IDLE**
  - `code_vld` → `cur_code`=`code_in`, `run`=1, go to RUN.
  - `flush` alone → no push, stay in IDLE.
- **RUN, `code_vld` with the same code**
  - `run` < 2^RUN_W−1 → increment `run`.
  - `run` = 2^RUN_W−1 (saturated) → push `{cur_code, max}`, then `run`=1.
- **RUN, `code_vld` with a different code** → push `{cur_code, run}`, `cur_code`=`code_in`, `run`=1.
- **RUN, `flush`**
  - Push `{cur_code, run}`.
  - If `code_vld` is also high that cycle, a new run starts with `code_in`, `run`=1, state RUN.
  - Otherwise go to IDLE.
  - `flush` with a same-code `code_vld` also closes the run; the new cycle's code starts a fresh run of 1.
- At most one push per cycle. Pop = `out_valid && out_ready`.
- **Push when full**
  - Accepted only if a pop occurs the same cycle.
  - Otherwise the record is dropped and `overflow` is set. `overflow` clears only on reset.
- **Push when empty:** the record appears on `out_data` the next cycle.
- **Simultaneous push and pop:** `level` is unchanged.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are derived from `level`.
- **Empty:** `out_data` is forced to 0.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, state IDLE, `run`=0, `cur_code`=0.
- **Latency:** a code change sampled at edge N pushes at edge N; `out_valid` is high after edge N, i.e. in cycle N+1.
- `level` and `out_valid` are registered. `out_data` is combinational from the FIFO head register, with no extra read latency.
- **Reset mid-operation:** the open run and all FIFO contents are discarded immediately.
- `out_ready` while `out_valid`=0 has no effect.

## Configuration
- Macro `FSM_CODE_LOGGER_STATS_EN`.
- **Defined:** two extra outputs are added.
  - `rec_cnt[15:0]`: records accepted into the FIFO.
  - `drop_cnt[15:0]`: records dropped.
  - Both saturate at 16'hFFFF and reset to 0.
- **Undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Basic run:** reset, then `code_vld`=1 with code 5 for 4 cycles, then code 10 for 2 cycles, then `flush` with `out_ready`=1 → records `{5,4}` then `{10,2}`; `level` returns to 0.
- **Saturation:** `RUN_W`=4, code 10 held for 20 cycles, then `flush` → records `{10,15}` then `{10,5}`.
- **Full FIFO:** `out_ready`=0, alternate codes 5/10 every cycle for `DEPTH`+3 changes → `level`=`DEPTH`, `overflow`=1, first `DEPTH` records intact; with the macro, `drop_cnt`=3.
- **Full with simultaneous pop:** FIFO full, push and pop in the same cycle → record accepted, `level` stays at `DEPTH`, `overflow` stays 0.
- **Flush with new code:** `flush` and `code_vld` (code 5) high together while in RUN on code 10 with `run`=3 → push `{10,3}`; next record starts code 5, `run` 1.
- **Reset mid-operation:** deassert `rstb` while `level`=3 → `out_valid`=0, `level`=0, `out_data`=0 immediately, `overflow` cleared.
